// File: rtl/rhd_pkg.sv
// Shared types and opcodes for the RHD2000 command sequencer.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package rhd_pkg;

    // Two-bit opcodes occupy command bits [15:14]; CALIBRATE is a full byte.
    localparam logic [1:0] OP_CONVERT   = 2'b00;
    localparam logic [7:0] OP_CALIBRATE = 8'h55;
    localparam logic [1:0] OP_WRITE     = 2'b10;
    localparam logic [1:0] OP_READ      = 2'b11;
    localparam logic [5:0] DUMMY_REG    = 6'd63;

    // What a finished frame's result (returned two frames later) is for.
    typedef enum logic [1:0] {
        NONE,
        CONV,
        HOSTREAD,
        OTHER
    } tag_kind_e;

    typedef struct packed {
        tag_kind_e  kind;
        logic [5:0] chan;
    } tag_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_CAL,
        ST_CALWAIT,
        ST_SWEEP,
        ST_HOST,
        ST_FLUSH
    } seq_state_e;

    // Per-frame handshake with the SPI master.
    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_WAIT_DONE,
        PH_WAIT_IDLE,
        PH_GAP
    } phase_e;

    function automatic logic [15:0] cmd_read(input logic [5:0] reg_addr);
        return {OP_READ, reg_addr, 8'h00};
    endfunction

endpackage

// File: rtl/rhd_tag_pipe.sv
// Two-deep tag shift register; steers each popped result to the sample or host-read output.
// Latency: outputs register one cycle after push. Ports: push/flush/push_tag/result in; sample_* and host_r* out.
// Backpressure: none; outputs are one-cycle pulses the consumer must take.
module rhd_tag_pipe
    import rhd_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        push,
    input  logic        flush,
    input  tag_t        push_tag,
    input  logic [15:0] result,
    output logic        sample_valid,
    output logic [5:0]  sample_chan,
    output logic [15:0] sample_data,
    output logic        host_rvalid,
    output logic [7:0]  host_rdata
);

    localparam tag_t TAG_EMPTY = '{kind: NONE, chan: 6'd0};

    tag_t        tag0_q, tag0_d;   // frame that just finished
    tag_t        tag1_q, tag1_d;   // frame finished one frame earlier
    logic        sample_valid_q, sample_valid_d;
    logic [5:0]  sample_chan_q, sample_chan_d;
    logic [15:0] sample_data_q, sample_data_d;
    logic        host_rvalid_q, host_rvalid_d;
    logic [7:0]  host_rdata_q, host_rdata_d;

    always_comb begin
        tag0_d         = tag0_q;
        tag1_d         = tag1_q;
        sample_valid_d = 1'b0;
        sample_chan_d  = sample_chan_q;
        sample_data_d  = sample_data_q;
        host_rvalid_d  = 1'b0;
        host_rdata_d   = host_rdata_q;
        if (flush) begin
            tag0_d = TAG_EMPTY;
            tag1_d = TAG_EMPTY;
        end else if (push) begin
            tag0_d = push_tag;
            tag1_d = tag0_q;
            // The result arriving now belongs to the frame two back (tag1).
            unique case (tag1_q.kind)
                CONV: begin
                    sample_valid_d = 1'b1;
                    sample_chan_d  = tag1_q.chan;
                    sample_data_d  = result;
                end
                HOSTREAD: begin
                    host_rvalid_d = 1'b1;
                    host_rdata_d  = result[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tag0_q         <= TAG_EMPTY;
            tag1_q         <= TAG_EMPTY;
            sample_valid_q <= 1'b0;
            sample_chan_q  <= 6'd0;
            sample_data_q  <= 16'd0;
            host_rvalid_q  <= 1'b0;
            host_rdata_q   <= 8'd0;
        end else begin
            tag0_q         <= tag0_d;
            tag1_q         <= tag1_d;
            sample_valid_q <= sample_valid_d;
            sample_chan_q  <= sample_chan_d;
            sample_data_q  <= sample_data_d;
            host_rvalid_q  <= host_rvalid_d;
            host_rdata_q   <= host_rdata_d;
        end
    end

    assign sample_valid = sample_valid_q;
    assign sample_chan  = sample_chan_q;
    assign sample_data  = sample_data_q;
    assign host_rvalid  = host_rvalid_q;
    assign host_rdata   = host_rdata_q;

endmodule

// File: rtl/rhd_command_sequencer.sv
// RHD2000 command sequencer: power-up dummies, CALIBRATE, then CONVERT sweeps with one host access between sweeps.
// Latency: one frame per spi_start/spi_done handshake; results emerge the cycle after the done edge of the frame two later.
// Backpressure: paced entirely by spi_done; host_req is held until host_ack at a sweep boundary.
module rhd_command_sequencer
    import rhd_pkg::*;
#(
    parameter int NUM_CHANNELS = 32,
    parameter int INIT_DUMMIES = 2,
    parameter int CAL_DUMMIES  = 9
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        enable,
    output logic        spi_start,
    output logic [31:0] spi_cmd,
    input  logic        spi_done,
    input  logic [31:0] spi_result,
    input  logic        host_req,
    input  logic        host_we,
    input  logic [5:0]  host_addr,
    input  logic [7:0]  host_wdata,
    output logic        host_ack,
    output logic        host_rvalid,
    output logic [7:0]  host_rdata,
    output logic        sample_valid,
    output logic [5:0]  sample_chan,
    output logic [15:0] sample_data,
    output logic        running
);

    localparam logic [6:0] LAST_CHAN  = 7'(NUM_CHANNELS - 1);
    localparam logic [6:0] LAST_INIT  = 7'(INIT_DUMMIES - 1);
    localparam logic [6:0] LAST_CALW  = 7'(CAL_DUMMIES - 1);
    localparam logic [6:0] LAST_FLUSH = 7'd1;

    seq_state_e  state_q, state_d;
    phase_e      phase_q, phase_d;
    logic [6:0]  cnt_q, cnt_d;          // frame index within the current state
    logic        done_prev_q, done_prev_d;
    logic        spi_start_q, spi_start_d;
    logic [31:0] spi_cmd_q, spi_cmd_d;
    logic        host_ack_q, host_ack_d;
    tag_t        cur_tag_q, cur_tag_d;  // tag of the frame currently in flight
    logic [15:0] cmd16;
    tag_t        new_tag;
    logic        push;
    logic        flush;
    logic        unused_result_hi;

    assign unused_result_hi = ^spi_result[31:16];

    // Sequencing: frame handshake phase plus the state decision taken at each frame boundary.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        flush   = 1'b0;
        done_prev_d = spi_done;
        if (state_q == ST_IDLE) begin
            phase_d = PH_GAP;
            if (enable) begin
                state_d = ST_INIT;
                cnt_d   = 7'd0;
                phase_d = PH_ISSUE;
            end
        end else begin
            unique case (phase_q)
                PH_ISSUE: phase_d = PH_WAIT_DONE;
                PH_WAIT_DONE: begin
                    // Edge, not level: a long done pulse counts as one frame.
                    if (spi_done && !done_prev_q) begin
                        push    = 1'b1;
                        phase_d = PH_WAIT_IDLE;
                    end
                end
                PH_WAIT_IDLE: begin
                    if (!spi_done) begin
                        phase_d = PH_GAP;
                        cnt_d   = cnt_q + 7'd1;
                        if (!enable && state_q != ST_FLUSH) begin
                            state_d = ST_FLUSH;
                            cnt_d   = 7'd0;
                        end else begin
                            unique case (state_q)
                                ST_INIT: if (cnt_q == LAST_INIT) begin
                                    state_d = ST_CAL;
                                    cnt_d   = 7'd0;
                                end
                                ST_CAL: begin
                                    state_d = ST_CALWAIT;
                                    cnt_d   = 7'd0;
                                end
                                ST_CALWAIT: if (cnt_q == LAST_CALW) begin
                                    state_d = ST_SWEEP;
                                    cnt_d   = 7'd0;
                                end
                                ST_SWEEP: if (cnt_q == LAST_CHAN) begin
                                    state_d = host_req ? ST_HOST : ST_SWEEP;
                                    cnt_d   = 7'd0;
                                end
                                ST_HOST: begin
                                    state_d = ST_SWEEP;
                                    cnt_d   = 7'd0;
                                end
                                ST_FLUSH: if (cnt_q == LAST_FLUSH) begin
                                    state_d = ST_IDLE;
                                    cnt_d   = 7'd0;
                                    flush   = 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                PH_GAP: phase_d = PH_ISSUE;
                default: ;
            endcase
        end
    end

    // Frame launch: command, start pulse and tag are registered so they line up with the ISSUE cycle.
    always_comb begin
        spi_start_d = 1'b0;
        spi_cmd_d   = spi_cmd_q;
        host_ack_d  = 1'b0;
        cur_tag_d   = cur_tag_q;
        cmd16       = cmd_read(DUMMY_REG);
        new_tag     = '{kind: OTHER, chan: 6'd0};
        if (state_d != ST_IDLE && phase_d == PH_ISSUE) begin
            spi_start_d = 1'b1;
            unique case (state_d)
                ST_CAL: cmd16 = {OP_CALIBRATE, 8'h00};
                ST_SWEEP: begin
                    cmd16   = {OP_CONVERT, cnt_d[5:0], 8'h00};
                    new_tag = '{kind: CONV, chan: cnt_d[5:0]};
                end
                ST_HOST: begin
                    host_ack_d = 1'b1;
                    if (host_we) begin
                        cmd16 = {OP_WRITE, host_addr, host_wdata};
                    end else begin
                        cmd16   = {OP_READ, host_addr, 8'h00};
                        new_tag = '{kind: HOSTREAD, chan: 6'd0};
                    end
                end
                default: cmd16 = cmd_read(DUMMY_REG);
            endcase
            spi_cmd_d = {cmd16, 16'h0000};
            cur_tag_d = new_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            phase_q     <= PH_GAP;
            cnt_q       <= 7'd0;
            done_prev_q <= 1'b0;
            spi_start_q <= 1'b0;
            spi_cmd_q   <= 32'd0;
            host_ack_q  <= 1'b0;
            cur_tag_q   <= '{kind: NONE, chan: 6'd0};
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            done_prev_q <= done_prev_d;
            spi_start_q <= spi_start_d;
            spi_cmd_q   <= spi_cmd_d;
            host_ack_q  <= host_ack_d;
            cur_tag_q   <= cur_tag_d;
        end
    end

    rhd_tag_pipe u_tag_pipe (
        .clk          (clk),
        .rstn         (rstn),
        .push         (push),
        .flush        (flush),
        .push_tag     (cur_tag_q),
        .result       (spi_result[15:0]),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata)
    );

    assign spi_start = spi_start_q;
    assign spi_cmd   = spi_cmd_q;
    assign host_ack  = host_ack_q;
    assign running   = (state_q == ST_SWEEP) || (state_q == ST_HOST);

endmodule

// File: tb/tb_rhd_command_sequencer.sv
// Bench for rhd_command_sequencer with NUM_CHANNELS=4 and a behavioural SPI master.
// Latency: master answers each start after a random delay and holds done for a random width.
// Backpressure: n/a (bench).
module tb_rhd_command_sequencer;

    localparam int NCH = 4;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic        spi_start;
    logic [31:0] spi_cmd;
    logic        spi_done;
    logic [31:0] spi_result;
    logic        host_req;
    logic        host_we;
    logic [5:0]  host_addr;
    logic [7:0]  host_wdata;
    logic        host_ack;
    logic        host_rvalid;
    logic [7:0]  host_rdata;
    logic        sample_valid;
    logic [5:0]  sample_chan;
    logic [15:0] sample_data;
    logic        running;

    int n_asserts = 0;
    int n_fail    = 0;
    int frame_idx = 0;
    logic [15:0] cmd_hist[$];   // commands in issue order since the tag pipe was last emptied
    logic [15:0] res_hist[$];   // 16-bit result returned at the end of each of those frames

    rhd_command_sequencer #(
        .NUM_CHANNELS (NCH),
        .INIT_DUMMIES (2),
        .CAL_DUMMIES  (9)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .spi_start    (spi_start),
        .spi_cmd      (spi_cmd),
        .spi_done     (spi_done),
        .spi_result   (spi_result),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .sample_valid (sample_valid),
        .sample_chan  (sample_chan),
        .sample_data  (sample_data),
        .running      (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_spi_start"},    32'(spi_start),    32'd0);
        check({tag, "_spi_cmd"},      spi_cmd,           32'd0);
        check({tag, "_host_ack"},     32'(host_ack),     32'd0);
        check({tag, "_host_rvalid"},  32'(host_rvalid),  32'd0);
        check({tag, "_host_rdata"},   32'(host_rdata),   32'd0);
        check({tag, "_sample_valid"}, 32'(sample_valid), 32'd0);
        check({tag, "_sample_chan"},  32'(sample_chan),  32'd0);
        check({tag, "_sample_data"},  32'(sample_data),  32'd0);
        check({tag, "_running"},      32'(running),      32'd0);
    endtask

    // One frame as seen by the SPI master. mode 1 drops enable during the frame,
    // mode 2 asserts reset while done is high and abandons the frame.
    task automatic do_frame(input logic [15:0] exp_cmd, input logic exp_ack,
                            input logic exp_run, input int mode);
        int n;
        int k;
        logic [15:0] res;
        logic [15:0] pc;
        logic exp_sv;
        logic exp_hv;
        n = 0;
        while (spi_start !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(spi_start), 32'd1);
        if (spi_start !== 1'b1) return;
        check("spi_cmd",  spi_cmd, {exp_cmd, 16'h0000});
        check("host_ack", 32'(host_ack), 32'(exp_ack));
        check("running",  32'(running),  32'(exp_run));
        if (exp_ack) host_req = 1'b0;
        cmd_hist.push_back(exp_cmd);
        repeat ($urandom_range(1, 5)) begin
            @(negedge clk);
            check("quiet_wait", 32'({spi_start, host_ack, sample_valid, host_rvalid}), 32'd0);
        end
        res = 16'hA000 + 16'(frame_idx);
        frame_idx++;
        spi_result = {16'($urandom), res};
        spi_done   = 1'b1;
        if (mode == 1) enable = 1'b0;
        if (mode == 2) begin
            rstn = 1'b0;
            @(negedge clk);
            check_zero("mid_reset");
            spi_done = 1'b0;
            cmd_hist.delete();
            res_hist.delete();
            return;
        end
        res_hist.push_back(res);
        k = res_hist.size() - 1;
        exp_sv = 1'b0;
        exp_hv = 1'b0;
        pc     = 16'h0000;
        if (k >= 2) begin
            pc     = cmd_hist[k-2];
            exp_sv = (pc[15:14] == 2'b00);
            exp_hv = (pc[15:14] == 2'b11) && (pc[13:8] != 6'd63);
        end
        @(negedge clk);
        check("sample_valid", 32'(sample_valid), 32'(exp_sv));
        if (exp_sv) begin
            check("sample_chan", 32'(sample_chan), 32'(pc[13:8]));
            check("sample_data", 32'(sample_data), 32'(res));
        end
        check("host_rvalid", 32'(host_rvalid), 32'(exp_hv));
        if (exp_hv) check("host_rdata", 32'(host_rdata), 32'(res[7:0]));
        repeat ($urandom_range(1, 4)) begin
            @(negedge clk);
            check("quiet_done", 32'({spi_start, host_ack, sample_valid, host_rvalid}), 32'd0);
        end
        spi_done   = 1'b0;
        spi_result = $urandom;
    endtask

    task automatic startup();
        repeat (2) do_frame(16'hFF00, 1'b0, 1'b0, 0);
        do_frame(16'h5500, 1'b0, 1'b0, 0);
        repeat (9) do_frame(16'hFF00, 1'b0, 1'b0, 0);
    endtask

    task automatic sweep(input int raise_at);
        for (int c = 0; c < NCH; c++) begin
            if (c == raise_at) host_req = 1'b1;
            do_frame({2'b00, 6'(c), 8'h00}, 1'b0, 1'b1, 0);
        end
    endtask

    initial begin
        int n;
        logic       we;
        logic [5:0] addr;
        logic [7:0] wd;
        rstn = 1'b0; enable = 1'b0; spi_done = 1'b0; spi_result = 32'd0;
        host_req = 1'b0; host_we = 1'b0; host_addr = 6'd0; host_wdata = 8'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rstn = 1'b1;
        n = 0;
        repeat (10) begin
            @(negedge clk);
            if (spi_start) n++;
        end
        check("no_start_disabled", 32'(n), 32'd0);

        // Power-up and plain sweeps.
        enable = 1'b1;
        startup();
        sweep(-1);
        sweep(-1);

        // Host WRITE r5 = 0x3C raised mid-sweep.
        host_we = 1'b1; host_addr = 6'd5; host_wdata = 8'h3C;
        sweep(2);
        do_frame(16'h853C, 1'b1, 1'b1, 0);
        sweep(-1);

        // Host READ r40.
        host_we = 1'b0; host_addr = 6'd40; host_wdata = 8'h00;
        sweep(1);
        do_frame(16'hE800, 1'b1, 1'b1, 0);
        sweep(-1);

        // Random host accesses.
        for (int i = 0; i < 6; i++) begin
            we   = 1'($urandom_range(0, 1));
            addr = 6'($urandom_range(0, 62));
            wd   = 8'($urandom);
            host_we = we; host_addr = addr; host_wdata = wd;
            sweep($urandom_range(1, NCH - 1));
            do_frame(we ? {2'b10, addr, wd} : {2'b11, addr, 8'h00}, 1'b1, 1'b1, 0);
        end
        sweep(-1);

        // Disable during CONVERT(2): frame completes, two flush dummies, then idle.
        do_frame(16'h0000, 1'b0, 1'b1, 0);
        do_frame(16'h0100, 1'b0, 1'b1, 0);
        do_frame(16'h0200, 1'b0, 1'b1, 1);
        do_frame(16'hFF00, 1'b0, 1'b0, 0);
        do_frame(16'hFF00, 1'b0, 1'b0, 0);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            if (spi_start) n++;
        end
        check("idle_no_start", 32'(n), 32'd0);
        check("idle_running", 32'(running), 32'd0);
        cmd_hist.delete();
        res_hist.delete();

        // Re-enable repeats init and calibration; then reset mid-frame.
        enable = 1'b1;
        startup();
        sweep(-1);
        do_frame(16'h0000, 1'b0, 1'b1, 0);
        do_frame(16'h0100, 1'b0, 1'b1, 2);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        do_frame(16'hFF00, 1'b0, 1'b0, 0);
        do_frame(16'hFF00, 1'b0, 1'b0, 0);
        do_frame(16'h5500, 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
